// File: rtl/div_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_unit_pkg                                                         |
// | Shared state encoding and sizing helpers for the multicycle divider. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package div_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

    // The counter must be able to hold WIDTH itself, not only WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_unit_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_unit_step                                                        |
// | One combinational restoring-division iteration on magnitudes.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module div_unit_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;

    // {rem,quo} shifted left by one; the extra top bit keeps the compare exact.
    assign w_shift  = {rem, quo[WIDTH-1]};
    assign w_ge     = (w_shift >= {2'b00, divisor});
    assign w_diff   = w_shift[WIDTH:0] - {1'b0, divisor};
    assign rem_next = w_ge ? w_diff : w_shift[WIDTH:0];
    assign quo_next = {quo[WIDTH-2:0], w_ge};

endmodule
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_unit                                                             |
// | Multicycle signed divider: radix-2 restoring, sign fix-up, div0 flag.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int               CNT_W  = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    div_state_e       r_state;
    div_state_e       w_next_state;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_divisor;
    logic             r_sign_q;
    logic             r_sign_r;

    logic             w_accept;
    logic             w_b_zero;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

    // A new operation may start from IDLE or in the DONE cycle of the previous one.
    assign w_accept = ctrl_DIV && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_b_zero = (data_operandB == '0);
    assign w_abs_a  = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign w_abs_b  = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    div_unit_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (r_rem),
        .quo      (r_quo),
        .divisor  (r_divisor),
        .rem_next (w_rem_next),
        .quo_next (w_quo_next)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (ctrl_DIV) begin
                    w_next_state = w_b_zero ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_count == C_LAST) begin
                    w_next_state = ST_FIX;
                end
            end
            ST_FIX: begin
                w_next_state = ST_DONE;
            end
            ST_DONE: begin
                if (ctrl_DIV) begin
                    w_next_state = w_b_zero ? ST_DONE : ST_RUN;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count        <= '0;
            r_rem          <= '0;
            r_quo          <= '0;
            r_divisor      <= '0;
            r_sign_q       <= 1'b0;
            r_sign_r       <= 1'b0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
        end else if (w_accept) begin
            r_count   <= '0;
            r_rem     <= '0;
            r_quo     <= w_abs_a;
            r_divisor <= w_abs_b;
            r_sign_q  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            r_sign_r  <= data_operandA[WIDTH-1];
            // Divide-by-zero skips straight to DONE, so results are loaded here.
            if (w_b_zero) begin
                data_result    <= '0;
                data_remainder <= data_operandA;
                data_exception <= 1'b1;
            end
        end else if (r_state == ST_RUN) begin
            r_rem   <= w_rem_next;
            r_quo   <= w_quo_next;
            r_count <= r_count + CNT_W'(1);
        end else if (r_state == ST_FIX) begin
            data_result    <= r_sign_q ? -r_quo : r_quo;
            data_remainder <= r_sign_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
            data_exception <= 1'b0;
        end
    end

    assign data_resultRDY = (r_state == ST_DONE);
    assign busy           = (r_state != ST_IDLE);

endmodule
`default_nettype wire
